mmio_rw_ctrl: RTL and testbench
===============================

Name: mmio_rw_ctrl

Overview:
- Next-generation MMIO device controller for the AXI-diff core. Handles both reads and writes to on-chip memory-mapped devices using the existing start/req/ack handshake.
- Owns the RTC counter, CLINT mtime and mtimecmp, and a parametrised bank of scratch registers.
- Adds byte-strobed writes, configurable response latency, unmapped-address error reporting and a level timer interrupt.
- Sits between the memory-stage MMIO path and the interrupt logic.

Parameters:
- DATA_W, 64, data and register width in bits (multiple of 8).
- ADDR_W, 64, address width.
- RTC_ADDR, 64'h0200_BFF8, RTC read address.
- MTIME_ADDR, 64'h0200_BFF0, mtime address (read/write).
- MTIMECMP_ADDR, 64'h0200_4000, mtimecmp address (read/write).
- SCR_BASE, 64'h0200_8000, base address of scratch bank.
- SCR_NUM, 4, number of scratch registers (1..16), stride DATA_W/8 bytes.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).
- RESP_LAT, 1, cycles from accept to req assertion (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request strobe.
- ren  in  1  read request, sampled with start.
- wen  in  1  write request, sampled with start.
- addr  in  ADDR_W  request address, sampled with start.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables.
- ack  in  1  requester consumed response.
- req  out  1  response valid.
- rdata  out  DATA_W  read data, valid while req.
- err  out  1  unmapped address or illegal access, valid while req.
- busy  out  1  transaction in flight (state != IDLE).
- o_mtime_irq  out  1  level, mtime >= mtimecmp.

Behaviour:
- Reset (rst==0 at posedge): req=0, rdata=0, err=0, busy=0, state=IDLE, mtime=0, mtimecmp=all-ones, RTC=0, scratch=0, tick counter=0. Consequence: o_mtime_irq=0 after reset.
- FSM states:
  - IDLE: on start & (ren|wen), latch addr, wdata, wstrb and op, load lat_cnt=RESP_LAT-1, go WAIT. start without ren/wen is ignored. ren&wen together is treated as a write.
  - WAIT: decrement lat_cnt; at 0, perform the access, register rdata/err, assert req, go RESP. RESP_LAT=1 gives req on the 2nd cycle after start.
  - RESP: hold req, rdata and err stable until ack. On ack, req=0 next cycle and go IDLE. ack in any other state is ignored. start outside IDLE is ignored (no queuing).
- Access rules:
  - Reads return the register value sampled in the access cycle.
  - Write merge: new = (old & ~mask) | (wdata & mask), mask expanded from wstrb. wstrb=0 writes nothing, no err.
  - RTC is read-only. A write to it sets err=1 and does not modify it.
  - Unmapped address: err=1. A read returns rdata=0.
  - Address compare is exact and full-width. Misaligned scratch addresses are unmapped.
- Timers:
  - RTC increments every clk, wrapping at 2^DATA_W.
  - mtime increments when the tick counter reaches TICK_DIV-1. Wraps from all-ones to 0; no sticky overflow.
  - A software write to mtime in the same cycle as a tick: the write wins and the tick is dropped.
  - o_mtime_irq is registered: mtime >= mtimecmp (unsigned), one-cycle latency. Writing mtimecmp above mtime deasserts it on the following cycle.
- Reset mid-transaction: abort, return to IDLE, req drops immediately at that edge, pending write is discarded.

Decomposition:
- Shared defines/package:
  - Default device addresses (RTC, MTIME, MTIMECMP, SCR base).
  - FSM state encoding (IDLE=0, WAIT=1, RESP=2).
  - Byte-mask expansion function.
- One sub-module, mmio_timer: RTC, mtime, tick divider, mtimecmp and irq compare, with read/write ports driven by the FSM.
- Scratch bank and FSM stay in the top level.

Test Plan:
- Read RTC after reset: start, ren, addr=RTC_ADDR at cycle 10, RESP_LAT=1 -> req high 2 cycles later, rdata=11, err=0, held until ack.
- mtimecmp strobed write: write 64'h0000_0000_0000_0020, wstrb=8'hFF. Then write wdata=64'hAA00 with wstrb=8'h02 -> readback 64'h0000_0000_0000_AA20.
- Timer interrupt, TICK_DIV=4: mtimecmp=3, o_mtime_irq rises at cycle 13±1 after reset. Writing mtimecmp=100 deasserts it the following cycle.
- Errors: write to RTC_ADDR -> err=1, RTC unchanged. Read at SCR_BASE+3 -> err=1, rdata=0. Read scratch[SCR_NUM-1] -> err=0.
- Handshake: RESP_LAT=3, ack withheld 5 cycles -> req stays high with rdata stable. start pulses during WAIT/RESP are ignored. ack gives req=0 next cycle, and a new start is accepted then.
- Reset abort: rst=0 one cycle during WAIT of a scratch write -> busy=0, req=0, scratch reads 0 afterward.

Source files
------------

// File: rtl/mmio_rw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mmio_rw_ctrl_pkg
//   Shared definitions for the MMIO read/write controller:
//     - default device addresses (RTC, mtime, mtimecmp, scratch bank base)
//     - transaction FSM state encoding
//     - byte-strobe to bit-mask expansion helper
// -----------------------------------------------------------------------------
package mmio_rw_ctrl_pkg;

    localparam logic [63:0] DEF_RTC_ADDR      = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] DEF_MTIME_ADDR    = 64'h0000_0000_0200_BFF0;
    localparam logic [63:0] DEF_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
    localparam logic [63:0] DEF_SCR_BASE      = 64'h0000_0000_0200_8000;

    // Widest data path the mask helper supports; callers size-cast the result
    // down to their own DATA_W.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Each strobe bit enables one byte lane of the mask.
    function automatic logic [MAX_DATA_W-1:0] expand_strb(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mmio_rw_ctrl_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//   Free-running RTC, CLINT mtime with tick divider, mtimecmp and the level
//   timer interrupt. Register writes arrive already byte-merged from the
//   controller FSM.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low
//   mtime_we_i     load mtime from wdata_i (wins over a coincident tick)
//   mtimecmp_we_i  load mtimecmp from wdata_i
//   wdata_i        merged write value
//   rtc_o          RTC counter value
//   mtime_o        mtime value
//   mtimecmp_o     mtimecmp value
//   irq_o          registered level interrupt, mtime >= mtimecmp (unsigned)
// -----------------------------------------------------------------------------
module mmio_timer #(
    parameter int DATA_W   = 64,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mtime_we_i,
    input  logic              mtimecmp_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rtc_o,
    output logic [DATA_W-1:0] mtime_o,
    output logic [DATA_W-1:0] mtimecmp_o,
    output logic              irq_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DATA_W-1:0] rtc_q;
    logic [DATA_W-1:0] mtime_q;
    logic [DATA_W-1:0] mtimecmp_q;
    logic [CNT_W-1:0]  tick_cnt_q;
    logic              irq_q;
    logic              tick;

    assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            rtc_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            tick_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rtc_q      <= rtc_q + DATA_W'(1);
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CNT_W'(1);
            // A software write takes priority; the coincident tick is lost.
            if (mtime_we_i) begin
                mtime_q <= wdata_i;
            end else if (tick) begin
                mtime_q <= mtime_q + DATA_W'(1);
            end
            if (mtimecmp_we_i) begin
                mtimecmp_q <= wdata_i;
            end
            // Compares current register values, so the level follows any
            // mtime/mtimecmp change one cycle later.
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign rtc_o      = rtc_q;
    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/mmio_rw_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_rw_ctrl
//   MMIO device controller between the memory-stage MMIO path and the
//   interrupt logic. Accepts one read or write per start strobe, waits
//   RESP_LAT cycles, performs the access and holds the response until ack.
//   Owns the timer block (RTC, mtime, mtimecmp) and a bank of scratch regs.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low (aborts any transaction)
//   start        one-cycle request strobe
//   ren / wen    read / write request, sampled with start (both = write)
//   addr         request address
//   wdata        write data
//   wstrb        byte enables
//   ack          requester consumed the response
//   req          response valid
//   rdata        read data, valid while req
//   err          unmapped address or illegal access, valid while req
//   busy         transaction in flight
//   o_mtime_irq  level timer interrupt
// -----------------------------------------------------------------------------
module mmio_rw_ctrl
    import mmio_rw_ctrl_pkg::*;
#(
    parameter int                DATA_W        = 64,
    parameter int                ADDR_W        = 64,
    parameter logic [ADDR_W-1:0] RTC_ADDR      = ADDR_W'(DEF_RTC_ADDR),
    parameter logic [ADDR_W-1:0] MTIME_ADDR    = ADDR_W'(DEF_MTIME_ADDR),
    parameter logic [ADDR_W-1:0] MTIMECMP_ADDR = ADDR_W'(DEF_MTIMECMP_ADDR),
    parameter logic [ADDR_W-1:0] SCR_BASE      = ADDR_W'(DEF_SCR_BASE),
    parameter int                SCR_NUM       = 4,
    parameter int                TICK_DIV      = 1,
    parameter int                RESP_LAT      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                ren,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                ack,
    output logic                req,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                busy,
    output logic                o_mtime_irq
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LAT_W  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    // Transaction registers
    state_e             state_q;
    logic [LAT_W-1:0]   lat_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic               req_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    // Scratch bank
    logic [DATA_W-1:0]  scr_q [SCR_NUM];

    // Access-cycle decode
    logic               access;
    logic               do_write;
    logic               sel_rtc;
    logic               sel_mtime;
    logic               sel_cmp;
    logic [SCR_NUM-1:0] scr_sel;
    logic               hit;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  old_val;
    logic [DATA_W-1:0]  merged;
    logic               mtime_we;
    logic               cmp_we;
    logic [DATA_W-1:0]  rdata_d;
    logic               err_d;

    // Timer outputs
    logic [DATA_W-1:0]  rtc_val;
    logic [DATA_W-1:0]  mtime_val;
    logic [DATA_W-1:0]  cmp_val;
    logic               irq;

    mmio_timer #(
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .mtime_we_i    (mtime_we),
        .mtimecmp_we_i (cmp_we),
        .wdata_i       (merged),
        .rtc_o         (rtc_val),
        .mtime_o       (mtime_val),
        .mtimecmp_o    (cmp_val),
        .irq_o         (irq)
    );

    always_comb begin
        access    = (state_q == ST_WAIT) && (lat_q == '0);
        mask      = DATA_W'(expand_strb(MAX_STRB_W'(wstrb_q)));
        sel_rtc   = (addr_q == RTC_ADDR);
        sel_mtime = (addr_q == MTIME_ADDR);
        sel_cmp   = (addr_q == MTIMECMP_ADDR);

        // Exact full-width match against each slot address; misaligned or
        // out-of-range offsets simply match nothing.
        scr_sel = '0;
        for (int i = 0; i < SCR_NUM; i++) begin
            if (addr_q == SCR_BASE + ADDR_W'(i * STRB_W)) begin
                scr_sel[i] = 1'b1;
            end
        end

        old_val = '0;
        if (sel_rtc) begin
            old_val = rtc_val;
        end else if (sel_mtime) begin
            old_val = mtime_val;
        end else if (sel_cmp) begin
            old_val = cmp_val;
        end else begin
            for (int i = 0; i < SCR_NUM; i++) begin
                if (scr_sel[i]) begin
                    old_val = scr_q[i];
                end
            end
        end

        hit    = sel_rtc || sel_mtime || sel_cmp || (|scr_sel);
        merged = (old_val & ~mask) | (wdata_q & mask);

        // An empty strobe must not touch mtime at all, otherwise rewriting
        // its own value would still swallow a tick.
        do_write = access && wr_q && (wstrb_q != '0);
        mtime_we = do_write && sel_mtime;
        cmp_we   = do_write && sel_cmp;

        err_d   = !hit || (wr_q && sel_rtc);
        rdata_d = (!wr_q && hit) ? old_val : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (ren || wen)) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        wr_q    <= wen;
                        lat_q   <= LAT_W'(RESP_LAT - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q == '0) begin
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                        req_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SCR_NUM; i++) begin
                scr_q[i] <= '0;
            end
        end else if (do_write) begin
            for (int i = 0; i < SCR_NUM; i++) begin
                if (scr_sel[i]) begin
                    scr_q[i] <= merged;
                end
            end
        end
    end

    assign req         = req_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign o_mtime_irq = irq;

endmodule

// File: tb/tb_mmio_rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_rw_ctrl
//   Directed bench for mmio_rw_ctrl. Instance 0 uses default parameters
//   (RESP_LAT=1, TICK_DIV=1); instance 1 uses RESP_LAT=3, TICK_DIV=4.
// -----------------------------------------------------------------------------
module tb_mmio_rw_ctrl;

    localparam logic [63:0] RTC_A = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] MTM_A = 64'h0000_0000_0200_BFF0;
    localparam logic [63:0] CMP_A = 64'h0000_0000_0200_4000;
    localparam logic [63:0] SCR_A = 64'h0000_0000_0200_8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        start_s [2];
    logic        ren_s   [2];
    logic        wen_s   [2];
    logic        ack_s   [2];
    logic [63:0] addr_s  [2];
    logic [63:0] wdata_s [2];
    logic [7:0]  wstrb_s [2];

    logic        req0, req1, err0, err1, busy0, busy1, irq0, irq1;
    logic [63:0] rdata0, rdata1;

    int vecs  = 0;
    int fails = 0;
    int cyc [2];

    mmio_rw_ctrl u_dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .ren(ren_s[0]), .wen(wen_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .wstrb(wstrb_s[0]), .ack(ack_s[0]),
        .req(req0), .rdata(rdata0), .err(err0), .busy(busy0), .o_mtime_irq(irq0)
    );

    mmio_rw_ctrl #(.RESP_LAT(3), .TICK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .ren(ren_s[1]), .wen(wen_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .wstrb(wstrb_s[1]), .ack(ack_s[1]),
        .req(req1), .rdata(rdata1), .err(err1), .busy(busy1), .o_mtime_irq(irq1)
    );

    // Cycles since the last reset edge; equals the RTC value after each edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_s[d]) cyc[d] <= 0;
            else           cyc[d] <= cyc[d] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic req_of(input int d);
        return (d == 0) ? req0 : req1;
    endfunction
    function automatic logic err_of(input int d);
        return (d == 0) ? err0 : err1;
    endfunction
    function automatic logic [63:0] rdata_of(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] s);
        start_s[d] = 1'b1;
        ren_s[d]   = ~w;
        wen_s[d]   = w;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        wstrb_s[d] = s;
        step();
        start_s[d] = 1'b0;
        ren_s[d]   = 1'b0;
        wen_s[d]   = 1'b0;
    endtask

    task automatic wait_req(input int d);
        int n;
        n = 0;
        while (req_of(d) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk1("req_arrives", req_of(d), 1'b1);
    endtask

    task automatic xact(input int d, input logic w, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] s,
                        output logic [63:0] rd, output logic er, output int ac);
        issue(d, w, a, wd, s);
        wait_req(d);
        rd = rdata_of(d);
        er = err_of(d);
        ac = cyc[d];
        ack_s[d] = 1'b1;
        step();
        ack_s[d] = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          ac;
        int          cw;

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b0; start_s[d] = 1'b0; ren_s[d] = 1'b0; wen_s[d] = 1'b0;
            ack_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0; wstrb_s[d] = '0;
        end
        step();
        step();
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;

        chk1("rst_req", req0, 1'b0);
        chk ("rst_rdata", rdata0, 64'd0);
        chk1("rst_err", err0, 1'b0);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_irq", irq0, 1'b0);

        // RTC read with start in cycle 10
        repeat (10) step();
        issue(0, 1'b0, RTC_A, 64'd0, 8'h00);
        chk1("rtc_req_not_yet", req0, 1'b0);
        chk1("rtc_busy", busy0, 1'b1);
        step();
        chk1("rtc_req", req0, 1'b1);
        chk ("rtc_rdata", rdata0, 64'd11);
        chk1("rtc_err", err0, 1'b0);
        step();
        chk1("rtc_req_held", req0, 1'b1);
        chk ("rtc_rdata_held", rdata0, 64'd11);
        ack_s[0] = 1'b1;
        step();
        ack_s[0] = 1'b0;
        chk1("rtc_req_drop", req0, 1'b0);
        chk1("rtc_busy_drop", busy0, 1'b0);

        // start without ren/wen does nothing
        issue(0, 1'b0, RTC_A, 64'd0, 8'h00);
        ren_s[0] = 1'b0;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        wait_req(0);
        ack_s[0] = 1'b1; step(); ack_s[0] = 1'b0;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        chk1("bare_start_ignored", busy0, 1'b0);

        // mtimecmp strobed writes
        xact(0, 1'b1, CMP_A, 64'h20, 8'hFF, rd, er, ac);
        chk1("cmp_wr_err", er, 1'b0);
        xact(0, 1'b1, CMP_A, 64'hAA00, 8'h02, rd, er, ac);
        xact(0, 1'b0, CMP_A, 64'd0, 8'h00, rd, er, ac);
        chk ("cmp_merge", rd, 64'h0000_0000_0000_AA20);
        chk1("cmp_rd_err", er, 1'b0);

        // RTC is read-only
        xact(0, 1'b1, RTC_A, 64'd0, 8'hFF, rd, er, ac);
        chk1("rtc_wr_err", er, 1'b1);
        xact(0, 1'b0, RTC_A, 64'd0, 8'h00, rd, er, ac);
        chk ("rtc_unchanged", rd, 64'(ac - 1));

        // mtime write then read; ticks every cycle afterwards
        xact(0, 1'b1, MTM_A, 64'h1000, 8'hFF, rd, er, cw);
        xact(0, 1'b0, MTM_A, 64'd0, 8'h00, rd, er, ac);
        chk ("mtime_wr_rd", rd, 64'h1000 + 64'(ac - 1 - cw));

        // Unmapped / misaligned / out of range
        xact(0, 1'b0, SCR_A + 64'd3, 64'd0, 8'h00, rd, er, ac);
        chk1("misalign_err", er, 1'b1);
        chk ("misalign_rdata", rd, 64'd0);
        xact(0, 1'b0, SCR_A + 64'd32, 64'd0, 8'h00, rd, er, ac);
        chk1("past_bank_err", er, 1'b1);

        // Last scratch slot, partial write then empty-strobe write
        xact(0, 1'b1, SCR_A + 64'd24, 64'h1122_3344_5566_7788, 8'hF0, rd, er, ac);
        chk1("scr3_wr_err", er, 1'b0);
        xact(0, 1'b1, SCR_A + 64'd24, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, ac);
        chk1("scr3_nostrb_err", er, 1'b0);
        xact(0, 1'b0, SCR_A + 64'd24, 64'd0, 8'h00, rd, er, ac);
        chk ("scr3_rd", rd, 64'h1122_3344_0000_0000);
        chk1("scr3_rd_err", er, 1'b0);

        // Reset abort during WAIT of a scratch write
        issue(0, 1'b1, SCR_A + 64'd8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        rst_s[0] = 1'b0;
        step();
        rst_s[0] = 1'b1;
        chk1("abort_busy", busy0, 1'b0);
        chk1("abort_req", req0, 1'b0);
        xact(0, 1'b0, SCR_A + 64'd8, 64'd0, 8'h00, rd, er, ac);
        chk ("abort_scr1", rd, 64'd0);
        xact(0, 1'b0, SCR_A + 64'd24, 64'd0, 8'h00, rd, er, ac);
        chk ("abort_scr3_cleared", rd, 64'd0);

        // Instance 1: timer interrupt with TICK_DIV=4, RESP_LAT=3
        rst_s[1] = 1'b0;
        step();
        step();
        rst_s[1] = 1'b1;
        xact(1, 1'b1, CMP_A, 64'd3, 8'hFF, rd, er, ac);
        chk ("lat3_req_cycle", 64'(ac), 64'd4);
        chk1("lat3_req_drop", req1, 1'b0);
        while (irq1 !== 1'b1 && cyc[1] < 40) step();
        chk1("irq_rise", irq1, 1'b1);
        chk ("irq_rise_cycle", 64'(cyc[1]), 64'd13);
        issue(1, 1'b1, CMP_A, 64'd100, 8'hFF);
        wait_req(1);
        chk1("irq_hold_at_access", irq1, 1'b1);
        ack_s[1] = 1'b1;
        step();
        ack_s[1] = 1'b0;
        chk1("irq_clear", irq1, 1'b0);

        // Handshake: ignored starts, withheld ack
        xact(1, 1'b1, SCR_A + 64'd16, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, ac);
        issue(1, 1'b0, SCR_A + 64'd16, 64'd0, 8'h00);
        issue(1, 1'b1, SCR_A + 64'd16, 64'd0, 8'hFF);
        wait_req(1);
        chk ("hs_rdata", rdata1, 64'h0123_4567_89AB_CDEF);
        chk1("hs_err", err1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            start_s[1] = 1'b1; wen_s[1] = 1'b1; addr_s[1] = SCR_A + 64'd16;
            wdata_s[1] = 64'd0; wstrb_s[1] = 8'hFF;
            step();
            chk1("hs_req_held", req1, 1'b1);
            chk ("hs_rdata_stable", rdata1, 64'h0123_4567_89AB_CDEF);
        end
        start_s[1] = 1'b0;
        wen_s[1]   = 1'b0;
        ack_s[1] = 1'b1;
        step();
        ack_s[1] = 1'b0;
        chk1("hs_req_drop", req1, 1'b0);
        chk1("hs_idle", busy1, 1'b0);
        issue(1, 1'b0, SCR_A + 64'd16, 64'd0, 8'h00);
        chk1("hs_new_start", busy1, 1'b1);
        wait_req(1);
        chk ("hs_no_stray_write", rdata1, 64'h0123_4567_89AB_CDEF);
        ack_s[1] = 1'b1;
        step();
        ack_s[1] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
